aha_clock_select_ctrl: RTL and testbench

- Initiator side of the glitch-free clock-switch select handshake.
- Accepts a clock-source selection request from the platform controller register block and drives the shared SELECT_REQ bus to all clock-switch leaves.
- Waits for the outgoing leaf's SELECT_ACK to drop and the incoming leaf's SELECT_ACK to rise, synchronizing the acks from the foreign clock domains.
- Reports completion, the current selection, and timeouts.

---
 rtl/aha_clock_select_ctrl.sv | 179 +++++++++++++++++
 tb/tb_aha_clock_select_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aha_clock_select_ctrl.sv
// rtl/aha_clock_select_ctrl.sv - initiator of the glitch-free clock-switch select handshake
// Optional switch counter: define AHA_CLK_SEL_SWITCH_COUNT_EN.
module aha_clock_select_ctrl #(
  parameter int NUM_CLKS       = 6,
  parameter int SEL_W          = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RESET_SEL      = 0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                REQ_VALID,
  input  logic [SEL_W-1:0]    REQ_SEL,
  output logic                REQ_READY,
  output logic [SEL_W-1:0]    SELECT_REQ,
  input  logic [NUM_CLKS-1:0] SELECT_ACK_IN,
  output logic [SEL_W-1:0]    CUR_SEL,
  output logic                BUSY,
  output logic                DONE,
  output logic                TIMEOUT_ERR,
  output logic                SEL_ERR,
  output logic [15:0]         SWITCH_COUNT
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]    TIMER_MAX   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SEL_W-1:0] RESET_SEL_W = SEL_W'(RESET_SEL);
  localparam logic [SEL_W:0]   NUM_CLKS_W  = (SEL_W + 1)'(NUM_CLKS);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT_OFF,
    ST_WAIT_ON
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     sel_req_q, sel_req_d;
  logic [SEL_W-1:0]     cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0]     tgt_q, tgt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 done_q, done_d;
  logic                 sel_err_q, sel_err_d;
  logic                 tmo_q, tmo_d;

  logic [NUM_CLKS-1:0]  sync_q [SYNC_STAGES];
  logic [(1<<SEL_W)-1:0] ack_pad;
  logic [TW-1:0]        timer_nxt;
  logic                 timer_exp;
  logic                 sel_bad;
  logic                 on_hit;

  // The raw acks come from foreign clock domains; only this chain samples them.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= SELECT_ACK_IN;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Padding lets any select index the ack vector safely.
  always_comb begin
    ack_pad = '0;
    ack_pad[NUM_CLKS-1:0] = sync_q[SYNC_STAGES-1];
  end

  // Timer saturates so an exit in the cycle after expiry is still judged correctly.
  assign timer_exp = (timer_q == TIMER_MAX);
  assign timer_nxt = timer_exp ? timer_q : timer_q + TW'(1);
  assign sel_bad   = ({1'b0, REQ_SEL} >= NUM_CLKS_W);
  assign on_hit    = ack_pad[tgt_q];

  always_comb begin
    state_d   = state_q;
    sel_req_d = sel_req_q;
    cur_sel_d = cur_sel_q;
    tgt_d     = tgt_q;
    timer_d   = timer_q;
    done_d    = 1'b0;
    sel_err_d = 1'b0;
    tmo_d     = tmo_q;
    case (state_q)
      ST_INIT: begin
        timer_d = timer_nxt;
        if (ack_pad[RESET_SEL_W]) begin
          state_d = ST_IDLE;
        end else if (timer_exp) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        timer_d = '0;
        if (REQ_VALID) begin
          if (sel_bad) begin
            sel_err_d = 1'b1;
          end else if (REQ_SEL == cur_sel_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d     = REQ_SEL;
            sel_req_d = REQ_SEL;
            tmo_d     = 1'b0;
            state_d   = ST_WAIT_OFF;
          end
        end
      end
      ST_WAIT_OFF: begin
        timer_d = timer_nxt;
        if (!ack_pad[cur_sel_q]) begin
          state_d = ST_WAIT_ON;
        end else if (timer_exp) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_ON: begin
        timer_d = timer_nxt;
        if (on_hit) begin
          cur_sel_d = tgt_q;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else if (timer_exp) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_INIT;
      sel_req_q <= RESET_SEL_W;
      cur_sel_q <= RESET_SEL_W;
      tgt_q     <= RESET_SEL_W;
      timer_q   <= '0;
      done_q    <= 1'b0;
      sel_err_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_req_q <= sel_req_d;
      cur_sel_q <= cur_sel_d;
      tgt_q     <= tgt_d;
      timer_q   <= timer_d;
      done_q    <= done_d;
      sel_err_q <= sel_err_d;
      tmo_q     <= tmo_d;
    end
  end

`ifdef AHA_CLK_SEL_SWITCH_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
    end else if (state_q == ST_WAIT_ON && on_hit && count_q != 16'hFFFF) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign SWITCH_COUNT = count_q;
`else
  assign SWITCH_COUNT = 16'h0000;
`endif

  assign REQ_READY   = (state_q == ST_IDLE);
  assign BUSY        = (state_q != ST_IDLE);
  assign SELECT_REQ  = sel_req_q;
  assign CUR_SEL     = cur_sel_q;
  assign DONE        = done_q;
  assign SEL_ERR     = sel_err_q;
  assign TIMEOUT_ERR = tmo_q;

endmodule

// File: tb/tb_aha_clock_select_ctrl.sv
// tb/tb_aha_clock_select_ctrl.sv - randomized self-checking bench with a transaction-level model
module tb_aha_clock_select_ctrl;

  localparam int NCLK  = 6;
  localparam int S     = 2;
  localparam int TO    = 16;
  localparam int NEVER = 1000;
  localparam int BIG   = 1 << 30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_sel = '0;
  logic        req_ready;
  logic [2:0]  select_req;
  logic [5:0]  acks = '0;
  logic [2:0]  cur_sel;
  logic        busy, done, timeout_err, sel_err;
  logic [15:0] switch_count;

  aha_clock_select_ctrl #(
    .NUM_CLKS(NCLK), .SEL_W(3), .SYNC_STAGES(S), .TIMEOUT_CYCLES(TO), .RESET_SEL(0)
  ) dut (
    .CLK(clk), .RESET(reset), .REQ_VALID(req_valid), .REQ_SEL(req_sel),
    .REQ_READY(req_ready), .SELECT_REQ(select_req), .SELECT_ACK_IN(acks),
    .CUR_SEL(cur_sel), .BUSY(busy), .DONE(done), .TIMEOUT_ERR(timeout_err),
    .SEL_ERR(sel_err), .SWITCH_COUNT(switch_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int n_acc = 0, n_done = 0, n_err = 0;
  int fall_at [NCLK];
  int rise_at [NCLK];
  bit leaf_auto = 1'b0;

  // Reference state, derived only from requests and the scripted leaf behaviour.
  int m_cur = 0, m_selreq = 0, m_count = 0;
  bit m_tmo = 1'b0;

  always @(negedge clk) begin
    if (req_valid && req_ready) n_acc++;
    if (done) n_done++;
    if (sel_err) n_err++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int exp_cnt();
`ifdef AHA_CLK_SEL_SWITCH_COUNT_EN
    return m_count;
`else
    return 0;
`endif
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < NCLK; i++) begin
      fall_at[i] = -1;
      rise_at[i] = -1;
    end
  endtask

  // Advance one cycle; leaves change their raw acks just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (leaf_auto) begin
      acks = '0;
      acks[select_req] = 1'b1;
    end else begin
      for (int i = 0; i < NCLK; i++) begin
        if (fall_at[i] == cyc) acks[i] = 1'b0;
        if (rise_at[i] == cyc) acks[i] = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    int c;
    clear_sched();
    acks = '0;
    reset = 1'b1;
    req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    c = cyc;
    m_cur = 0; m_selreq = 0; m_count = 0; m_tmo = 1'b0;
    check("rst_busy", busy, 1);
    check("rst_ready", req_ready, 0);
    check("rst_selreq", select_req, 0);
    check("rst_cursel", cur_sel, 0);
    check("rst_done", done, 0);
    check("rst_selerr", sel_err, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_count", switch_count, 0);
    rise_at[0] = c + 3;
    while (!req_ready && cyc < c + 40) begin
      check("init_busy", busy, 1);
      tick();
    end
    check("init_exit_cycle", cyc - c, 3 + S + 1);
    check("init_cursel", cur_sel, 0);
    clear_sched();
  endtask

  task automatic do_switch(input int sel, input int off, input int on);
    int t, old, off_s, on_s, c_on, lim, l2, end_c, d0, e0, bn;
    bit to;
    t = cyc; old = m_cur; d0 = n_done; e0 = n_err;
    check("ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_sel = 3'(sel);
    if (sel >= NCLK) begin
      tick();
      req_valid = 1'b0;
      check("err_pulse", sel_err, 1);
      check("err_selreq", select_req, m_selreq);
      check("err_cursel", cur_sel, m_cur);
      check("err_busy", busy, 0);
      check("err_tmo", timeout_err, m_tmo);
      tick();
      check("err_once", n_err - e0, 1);
      check("err_nodone", n_done - d0, 0);
    end else if (sel == m_cur) begin
      tick();
      req_valid = 1'b0;
      check("same_done", done, 1);
      check("same_selreq", select_req, m_selreq);
      check("same_busy", busy, 0);
      check("same_count", switch_count, exp_cnt());
      check("same_tmo", timeout_err, m_tmo);
      tick();
      check("same_once", n_done - d0, 1);
    end else begin
      lim = t + TO;
      if (acks[old]) begin
        off_s = (off == NEVER) ? BIG : t + 1 + off + S;
        if (off != NEVER) fall_at[old] = t + 1 + off;
      end else begin
        off_s = t + 1;
      end
      if (!acks[sel]) begin
        on_s = (on == NEVER) ? BIG : t + 1 + on + S;
        if (on != NEVER) rise_at[sel] = t + 1 + on;
      end else begin
        on_s = t + 1;
      end
      if (off_s > lim) begin
        to = 1'b1;
        end_c = lim + 1;
      end else begin
        c_on = imax(off_s + 1, on_s);
        l2 = imax(lim, off_s + 1);
        if (c_on <= l2) begin
          to = 1'b0;
          end_c = c_on + 1;
        end else begin
          to = 1'b1;
          end_c = l2 + 1;
        end
      end
      tick();
      req_valid = 1'b0;
      check("selreq_t1", select_req, sel);
      check("busy_t1", busy, 1);
      check("tmo_clear_t1", timeout_err, 0);
      bn = 0;
      while (busy && cyc < t + TO + 8) begin
        bn++;
        tick();
      end
      if (!to) m_cur = sel;
      if (!to && m_count < 65535) m_count++;
      m_selreq = sel;
      m_tmo = to;
      check("end_latency", cyc - t, end_c - t);
      check("busy_cycles", bn, end_c - t - 1);
      check("done_at_end", done, int'(!to));
      check("timeout_err", timeout_err, int'(to));
      check("cur_sel", cur_sel, m_cur);
      check("selreq_end", select_req, m_selreq);
      check("count", switch_count, exp_cnt());
      while (cyc < t + TO + 8) tick();
      check("done_pulses", n_done - d0, int'(!to));
      clear_sched();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0, c0;
    clear_sched();
    do_reset();

    do_switch(2, 2, 4);
    do_switch(0, 1, 1);
    do_switch(0, 0, 0);
    do_switch(6, 0, 0);
    do_switch(3, 0, NEVER);
    check("tmo_cursel_kept", cur_sel, 0);
    check("tmo_selreq_tgt", select_req, 3);
    do_switch(2, 0, 3);

    // Hold REQ_VALID across two switches; REQ_SEL moves to 5 on the first DONE.
    leaf_auto = 1'b1;
    tick(); tick();
    a0 = n_acc; d0 = n_done;
    req_valid = 1'b1;
    req_sel = 3'd1;
    for (int k = 0; k < 60 && req_valid; k++) begin
      tick();
      if (done) begin
        if (req_sel == 3'd1) req_sel = 3'd5;
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    tick(); tick();
    m_cur = 5; m_selreq = 5; m_tmo = 1'b0;
    m_count = (m_count + 2 > 65535) ? 65535 : m_count + 2;
    check("held_accepts", n_acc - a0, 2);
    check("held_dones", n_done - d0, 2);
    check("held_cursel", cur_sel, 5);
    check("held_count", switch_count, exp_cnt());
    leaf_auto = 1'b0;
    tick(); tick(); tick(); tick();

    for (int it = 0; it < 40; it++) begin
      int sel, off, on;
      sel = int'($urandom_range(0, 7));
      off = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 15));
      on  = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 15));
      do_switch(sel, off, on);
    end

    // RESET while waiting for leaf 4 to acknowledge a 0->4 switch.
    do_reset();
    d0 = n_done;
    c0 = cyc;
    req_valid = 1'b1;
    req_sel = 3'd4;
    fall_at[0] = c0 + 1;
    tick();
    req_valid = 1'b0;
    while (cyc < c0 + 6) tick();
    check("mid_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_selreq", select_req, 0);
    check("mid_cursel", cur_sel, 0);
    check("mid_busy", busy, 1);
    check("mid_ready", req_ready, 0);
    check("mid_done", done, 0);
    clear_sched();
    rise_at[0] = cyc + 1;
    c0 = cyc;
    while (!req_ready && cyc < c0 + 40) tick();
    check("mid_reinit_ready", req_ready, 1);
    check("mid_no_done", n_done - d0, 0);
    check("mid_count", switch_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
